// File: rtl/switch_box_config_loader.sv
// switch_box_config_loader
// Word-serial configuration writer for universal_switch_box. Words are
// assembled LSB-first in a shadow register. The whole image is copied onto
// the c bus in one cycle, so the routing fabric never sees a partial pattern.
// Optional feature macro: CFG_READBACK_EN adds a readback stream of the
// committed image on rb_valid/rb_ready/rb_data, started by rb_start.
//
// Handshakes (cfg_in_* and rb_*): a word moves on a rising edge where valid
// and ready are both 1. The sender holds data stable while valid is high
// and ready is low. cfg_start has priority over a concurrent cfg_in word.
`timescale 1ns/1ps
module switch_box_config_loader #(
   parameter int WS = 7,
   parameter int WD = 6,
   parameter int WW = 8,
   localparam int CW = WS*6 + (WD/2)*6,
   localparam int NW = (CW + WW - 1) / WW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_start,
   input  logic          cfg_in_valid,
   output logic          cfg_in_ready,
   input  logic [WW-1:0] cfg_in_data,
   output logic          cfg_busy,
   output logic          cfg_done,
   output logic [CW-1:0] c
`ifdef CFG_READBACK_EN
   ,
   input  logic          rb_start,
   output logic          rb_valid,
   input  logic          rb_ready,
   output logic [WW-1:0] rb_data
`endif
);

   localparam int WCW = $clog2(NW + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;
`ifdef CFG_READBACK_EN
   localparam logic [1:0] RB     = 2'd3;
`endif

   logic [1:0]     state;
   logic [WCW-1:0] wcnt;
   logic [CW-1:0]  shadow;
   logic           xfer;
   logic           last_word;

   // A restart pulse wins over a word offered in the same cycle.
   assign xfer      = cfg_in_valid && cfg_in_ready && !cfg_start;
   assign last_word = (wcnt == WCW'(NW - 1));

`ifdef CFG_READBACK_EN
   logic [WCW-1:0] rcnt;
   logic           rb_last;

   assign rb_last = (rcnt == WCW'(NW - 1));

   // Word k of the committed image; bits above CW-1 read as zero.
   function automatic logic [WW-1:0] word_of(input logic [CW-1:0] img, input int k);
      logic [WW-1:0] w;
      w = '0;
      for (int b = 0; b < WW; b++) begin
         if (k*WW + b < CW) w[b] = img[k*WW + b];
      end
      return w;
   endfunction
`endif

   // Control FSM; ready, busy and done are registered so they are glitch-free decodes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wcnt         <= '0;
         cfg_in_ready <= 1'b0;
         cfg_busy     <= 1'b0;
         cfg_done     <= 1'b0;
         c            <= '0;
      end else begin
         cfg_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  state        <= LOAD;
                  wcnt         <= '0;
                  cfg_in_ready <= 1'b1;
                  cfg_busy     <= 1'b1;
               end
`ifdef CFG_READBACK_EN
               else if (rb_start) begin
                  state    <= RB;
                  cfg_busy <= 1'b1;
               end
`endif
            end
            LOAD: begin
               if (cfg_start) begin
                  wcnt <= '0;
               end else if (xfer) begin
                  wcnt <= wcnt + WCW'(1);
                  if (last_word) begin
                     state        <= COMMIT;
                     cfg_in_ready <= 1'b0;
                  end
               end
            end
            COMMIT: begin
               c        <= shadow;
               cfg_done <= 1'b1;
               cfg_busy <= 1'b0;
               state    <= IDLE;
            end
`ifdef CFG_READBACK_EN
            RB: begin
               if (rb_valid && rb_ready && rb_last) begin
                  state    <= IDLE;
                  cfg_busy <= 1'b0;
               end
            end
`endif
            default: begin
               state        <= IDLE;
               cfg_in_ready <= 1'b0;
               cfg_busy     <= 1'b0;
            end
         endcase
      end
   end

   // Shadow assembly: bit b belongs to word b/WW; padding bits of the last word are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
      end else begin
         for (int b = 0; b < CW; b++) begin
            if (xfer && (wcnt == WCW'(b / WW))) shadow[b] <= cfg_in_data[b % WW];
         end
      end
   end

`ifdef CFG_READBACK_EN
   // Readback streamer: presents word rcnt of the committed image while in RB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rb_valid <= 1'b0;
         rb_data  <= '0;
         rcnt     <= '0;
      end else if (state == IDLE && !cfg_start && rb_start) begin
         rb_valid <= 1'b1;
         rb_data  <= word_of(c, 0);
         rcnt     <= '0;
      end else if (state == RB && rb_valid && rb_ready) begin
         if (rb_last) begin
            rb_valid <= 1'b0;
            rb_data  <= '0;
         end else begin
            rcnt    <= rcnt + WCW'(1);
            rb_data <= word_of(c, int'(rcnt) + 1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Testbench for switch_box_config_loader: directed loads checked against a
// queue-based image model every cycle, plus literal expectations.
// Build with CFG_READBACK_EN defined to also exercise readback.
`timescale 1ns/1ps
module tb_switch_box_config_loader;

   localparam int WW = 8;
   localparam int CW = 60;
   localparam int NW = 8;

   logic          clk;
   logic          rst;
   logic          cfg_start;
   logic          cfg_in_valid;
   logic          cfg_in_ready;
   logic [WW-1:0] cfg_in_data;
   logic          cfg_busy;
   logic          cfg_done;
   logic [CW-1:0] c;
`ifdef CFG_READBACK_EN
   logic          rb_start;
   logic          rb_valid;
   logic          rb_ready;
   logic [WW-1:0] rb_data;
`endif

   switch_box_config_loader #(.WS(7), .WD(6), .WW(WW)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_start    (cfg_start),
      .cfg_in_valid (cfg_in_valid),
      .cfg_in_ready (cfg_in_ready),
      .cfg_in_data  (cfg_in_data),
      .cfg_busy     (cfg_busy),
      .cfg_done     (cfg_done),
      .c            (c)
`ifdef CFG_READBACK_EN
      ,
      .rb_start     (rb_start),
      .rb_valid     (rb_valid),
      .rb_ready     (rb_ready),
      .rb_data      (rb_data)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- scoreboard counters ----------------
   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks the words accepted in the current load; the image is their
   // LSB-first concatenation truncated to CW bits.
   logic [WW-1:0] got[$];
   bit            in_load;
   bit            commit_pending;
   bit            rb_active;
   int            rb_idx;
   logic [CW-1:0] exp_c;
   bit            exp_done;
   int            cyc = 0;
   bit            model_on = 0;
   int            done_cnt = 0;

   function automatic logic [CW-1:0] image_of();
      logic [NW*WW-1:0] w;
      w = '0;
      for (int i = 0; i < got.size(); i++) w[i*WW +: WW] = got[i];
      return w[CW-1:0];
   endfunction

   function automatic logic [WW-1:0] rb_word(input int k);
      logic [NW*WW-1:0] w;
      w = {{(NW*WW-CW){1'b0}}, exp_c};
      return w[k*WW +: WW];
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         got.delete();
         in_load        = 0;
         commit_pending = 0;
         rb_active      = 0;
         rb_idx         = 0;
         exp_c          = '0;
         exp_done       = 0;
      end else begin
         exp_done = 0;
         if (commit_pending) begin
            exp_c          = image_of();
            exp_done       = 1;
            commit_pending = 0;
         end else if (in_load) begin
            if (cfg_start) got.delete();
            else if (cfg_in_valid) begin
               got.push_back(cfg_in_data);
               if (got.size() == NW) begin
                  in_load        = 0;
                  commit_pending = 1;
               end
            end
         end else if (rb_active) begin
`ifdef CFG_READBACK_EN
            if (rb_ready) begin
               if (rb_idx == NW-1) rb_active = 0;
               else rb_idx++;
            end
`endif
         end else if (cfg_start) begin
            in_load = 1;
            got.delete();
         end
`ifdef CFG_READBACK_EN
         else if (rb_start) begin
            rb_active = 1;
            rb_idx    = 0;
         end
`endif
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #1;
      if (model_on && !rst) begin
         chk("cyc_c",     c,            exp_c);
         chk("cyc_ready", cfg_in_ready, in_load);
         chk("cyc_busy",  cfg_busy,     in_load || commit_pending || rb_active);
         chk("cyc_done",  cfg_done,     exp_done);
`ifdef CFG_READBACK_EN
         chk("cyc_rb_valid", rb_valid, rb_active);
         if (rb_active) chk("cyc_rb_data", rb_data, rb_word(rb_idx));
`endif
         if (cfg_done) done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   int s_cyc;

   task automatic pulse_start();
      @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      s_cyc = cyc;
   endtask

   task automatic send_word(input logic [WW-1:0] d, input int nb);
      repeat (nb) begin
         cfg_in_valid = 1'b0;
         @(negedge clk);
      end
      cfg_in_valid = 1'b1;
      cfg_in_data  = d;
      @(negedge clk);
   endtask

   task automatic wait_done(input int lat, input string name);
      int t;
      t = 0;
      while (cfg_done !== 1'b1 && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk({name, "_done_seen"}, cfg_done, 1);
      chk({name, "_latency"},   cyc - s_cyc, lat);
   endtask

   logic [WW-1:0] img_a[NW];
   int            d0;

   initial begin
      img_a = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
      rst          = 1'b1;
      cfg_start    = 1'b0;
      cfg_in_valid = 1'b0;
      cfg_in_data  = '0;
`ifdef CFG_READBACK_EN
      rb_start = 1'b0;
      rb_ready = 1'b0;
`endif
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_c",     c,            60'h0);
      chk("rst_ready", cfg_in_ready, 0);
      chk("rst_busy",  cfg_busy,     0);
      chk("rst_done",  cfg_done,     0);
      rst      = 1'b0;
      model_on = 1;

      // full load, back-to-back
      d0 = done_cnt;
      pulse_start();
      chk("load_ready_after_start", cfg_in_ready, 1);
      chk("load_busy_after_start",  cfg_busy,     1);
      for (int k = 0; k < NW; k++) send_word(img_a[k], 0);
      cfg_in_valid = 1'b0;
      chk("load_c_before_commit", c, 60'h0);
      wait_done(NW + 1, "load");
      chk("load_c", c, 60'hFCDAB8967452301);
      repeat (3) @(negedge clk);
      chk("load_done_once", done_cnt - d0, 1);

`ifdef CFG_READBACK_EN
      // readback with random rb_ready; a cfg_start mid-stream must be ignored
      begin
         logic [WW-1:0] rb_got[$];
         logic [WW-1:0] rb_exp[NW];
         int t;
         rb_exp = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'h0F};
         @(negedge clk);
         rb_start = 1'b1;
         rb_ready = 1'b0;
         @(negedge clk);
         rb_start = 1'b0;
         t = 0;
         while (rb_got.size() < NW && t < 200) begin
            rb_ready  = 1'($urandom_range(0, 1));
            cfg_start = (t == 3);
            if (rb_valid && rb_ready) rb_got.push_back(rb_data);
            @(negedge clk);
            t++;
         end
         rb_ready  = 1'b0;
         cfg_start = 1'b0;
         chk("rb_count", rb_got.size(), NW);
         for (int k = 0; k < NW && k < rb_got.size(); k++) chk("rb_word", rb_got[k], rb_exp[k]);
         repeat (2) @(negedge clk);
         chk("rb_end_valid", rb_valid,     0);
         chk("rb_end_ready", cfg_in_ready, 0);
         chk("rb_c_kept",    c,            60'hFCDAB8967452301);
      end
`endif

      // backpressure: valid pattern 1,0,0,1,0,0,...
      d0 = done_cnt;
      pulse_start();
      for (int k = 0; k < NW; k++) send_word(img_a[k], (k == 0) ? 0 : 2);
      cfg_in_valid = 1'b0;
      wait_done(NW + 1 + 2*(NW-1), "bp");
      chk("bp_c", c, 60'hFCDAB8967452301);
      repeat (3) @(negedge clk);
      chk("bp_done_once", done_cnt - d0, 1);

      // restart after 5 words with a concurrent word that must be dropped
      d0 = done_cnt;
      pulse_start();
      for (int k = 0; k < 5; k++) send_word(8'h11 + 8'(k), 0);
      cfg_start    = 1'b1;
      cfg_in_valid = 1'b1;
      cfg_in_data  = 8'h5A;
      @(negedge clk);
      cfg_start = 1'b0;
      s_cyc = cyc;
      for (int k = 0; k < NW; k++) send_word(8'hFF, 0);
      cfg_in_valid = 1'b0;
      wait_done(NW + 1, "restart");
      chk("restart_c", c, 60'hFFFFFFFFFFFFFFF);
      repeat (3) @(negedge clk);
      chk("restart_done_once", done_cnt - d0, 1);

      // known image, then reset three words into a second load
      pulse_start();
      for (int k = 0; k < NW; k++) send_word(8'h10 + 8'(k), 0);
      cfg_in_valid = 1'b0;
      wait_done(NW + 1, "known");
      chk("known_c", c, 60'h716151413121110);
      d0 = done_cnt;
      pulse_start();
      for (int k = 0; k < 3; k++) send_word(8'h33, 0);
      cfg_in_valid = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_c",     c,            60'h0);
      chk("midrst_ready", cfg_in_ready, 0);
      chk("midrst_busy",  cfg_busy,     0);
      chk("midrst_done",  cfg_done,     0);
`ifdef CFG_READBACK_EN
      chk("midrst_rb_valid", rb_valid, 0);
      chk("midrst_rb_data",  rb_data,  8'h00);
`endif
      repeat (2) @(negedge clk);
      chk("midrst_c_held",     c,            60'h0);
      chk("midrst_ready_held", cfg_in_ready, 0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_c_after", c, 60'h0);

      // complete load after the interrupted one
      pulse_start();
      for (int k = 0; k < NW; k++) send_word(8'hA0 + 8'(k), 0);
      cfg_in_valid = 1'b0;
      wait_done(NW + 1, "post_rst");
      chk("post_rst_c", c, 60'h7A6A5A4A3A2A1A0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
